// File: rtl/maze_game_ctrl.sv
// -----------------------------------------------------------------------------
// maze_game_ctrl
//
// Game controller for the maze video datapath. It holds the player and exit
// block coordinates used by the frame renderer, validates each requested move
// by reading the maze ROM through its second read port, paces held-key
// auto-repeat and the progress-bar strobe from the frame tick, and detects
// the win condition.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-low reset
//   i_frame_tick   one-cycle pulse per video frame
//   i_start        start/restart request (rising edge used)
//   i_up/i_down/i_left/i_right  debounced direction keys (level)
//   o_rom_en       maze ROM port-B read enable (high only in READ)
//   o_rom_addr     maze ROM port-B address = row + col*32
//   i_rom_data     maze ROM port-B data, valid one cycle after o_rom_en
//   o_player_bcol/o_player_brow  player block position
//   o_exit_bcol/o_exit_brow      exit block position (constant)
//   o_update_bar   progress-bar update level, held for one frame
//   o_win          player reached the exit
//   o_moves        accepted-move count, saturating at 1023
//                  (only when MAZE_CTRL_MOVE_CNT_EN is defined)
//
// Optional feature macro: MAZE_CTRL_MOVE_CNT_EN
// -----------------------------------------------------------------------------
module maze_game_ctrl #(
  parameter int          START_COL   = 1,
  parameter int          START_ROW   = 1,
  parameter int          EXIT_COL    = 38,
  parameter int          EXIT_ROW    = 28,
  parameter int          MAX_COL     = 39,
  parameter int          MAX_ROW     = 29,
  parameter logic [15:0] FLOOR_VAL   = 16'h0000,
  parameter int          MOVE_FRAMES = 8,
  parameter int          BAR_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_start,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_update_bar,
  output logic        o_win
`ifdef MAZE_CTRL_MOVE_CNT_EN
  ,
  output logic [9:0]  o_moves
`endif
);

  localparam int MV_W  = $clog2(MOVE_FRAMES + 1);
  localparam int BAR_W = $clog2(BAR_FRAMES + 1);

  localparam logic [5:0]       START_COL_C = 6'(START_COL);
  localparam logic [5:0]       START_ROW_C = 6'(START_ROW);
  localparam logic [5:0]       EXIT_COL_C  = 6'(EXIT_COL);
  localparam logic [5:0]       EXIT_ROW_C  = 6'(EXIT_ROW);
  localparam logic [5:0]       MAX_COL_C   = 6'(MAX_COL);
  localparam logic [5:0]       MAX_ROW_C   = 6'(MAX_ROW);
  localparam logic [MV_W-1:0]  MOVE_LOAD_C = MV_W'(MOVE_FRAMES);
  localparam logic [BAR_W-1:0] BAR_LAST_C  = BAR_W'(BAR_FRAMES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] WIN   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [5:0]       pcol_q, pcol_d, prow_q, prow_d;
  logic [5:0]       tcol_q, tcol_d, trow_q, trow_d;
  logic [MV_W-1:0]  move_cnt_q, move_cnt_d;
  logic [BAR_W-1:0] bar_cnt_q, bar_cnt_d;
  logic             bar_q, bar_d;
  logic             win_q, win_d;
  logic             rom_en_q, rom_en_d;
  logic [10:0]      rom_addr_q, rom_addr_d;
  logic             start_q;
`ifdef MAZE_CTRL_MOVE_CNT_EN
  logic [9:0]       moves_q, moves_d;
`endif

  logic       start_rise_s;
  logic       key_any_s;
  logic       active_s;
  logic       tgt_ok_s;
  logic [5:0] tgt_col_s, tgt_row_s;
  logic       accept_s;
  logic [5:0] new_col_s, new_row_s;

  assign start_rise_s = i_start & ~start_q;
  assign key_any_s    = i_up | i_down | i_left | i_right;
  assign active_s     = (state_q == WAIT) || (state_q == READ) || (state_q == CHECK);

  // A wall word is still passable when it is the exit block itself.
  assign accept_s  = (i_rom_data == FLOOR_VAL) ||
                     ((tcol_q == EXIT_COL_C) && (trow_q == EXIT_ROW_C));
  assign new_col_s = accept_s ? tcol_q : pcol_q;
  assign new_row_s = accept_s ? trow_q : prow_q;

  // Requested target from the held keys (up > down > left > right), no wrap.
  always_comb begin
    tgt_col_s = pcol_q;
    tgt_row_s = prow_q;
    tgt_ok_s  = 1'b0;
    if (i_up) begin
      tgt_row_s = prow_q - 6'd1;
      tgt_ok_s  = (prow_q != 6'd0);
    end else if (i_down) begin
      tgt_row_s = prow_q + 6'd1;
      tgt_ok_s  = (prow_q < MAX_ROW_C);
    end else if (i_left) begin
      tgt_col_s = pcol_q - 6'd1;
      tgt_ok_s  = (pcol_q != 6'd0);
    end else if (i_right) begin
      tgt_col_s = pcol_q + 6'd1;
      tgt_ok_s  = (pcol_q < MAX_COL_C);
    end else begin
      tgt_ok_s  = 1'b0;
    end
  end

  // Next-state logic for the FSM, position, timers and ROM request.
  always_comb begin
    state_d    = state_q;
    pcol_d     = pcol_q;
    prow_d     = prow_q;
    tcol_d     = tcol_q;
    trow_d     = trow_q;
    move_cnt_d = move_cnt_q;
    bar_cnt_d  = bar_cnt_q;
    bar_d      = bar_q;
    win_d      = win_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
`ifdef MAZE_CTRL_MOVE_CNT_EN
    moves_d    = moves_q;
`endif

    // Frame timers run in WAIT/READ/CHECK; a move load in CHECK overrides below.
    if (active_s && i_frame_tick) begin
      if (bar_cnt_q == BAR_LAST_C) begin
        bar_cnt_d = {BAR_W{1'b0}};
        bar_d     = 1'b1;
      end else begin
        bar_cnt_d = bar_cnt_q + BAR_W'(1);
        bar_d     = 1'b0;
      end
      if (move_cnt_q != {MV_W{1'b0}}) begin
        move_cnt_d = move_cnt_q - MV_W'(1);
      end else begin
        move_cnt_d = move_cnt_q;
      end
    end else begin
      bar_cnt_d  = bar_cnt_q;
    end

    case (state_q)
      IDLE: begin
        pcol_d     = START_COL_C;
        prow_d     = START_ROW_C;
        move_cnt_d = {MV_W{1'b0}};
        bar_cnt_d  = {BAR_W{1'b0}};
        bar_d      = 1'b0;
        win_d      = 1'b0;
`ifdef MAZE_CTRL_MOVE_CNT_EN
        moves_d    = 10'd0;
`endif
        if (start_rise_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Out-of-range targets are dropped here without touching the ROM.
        if (i_frame_tick && (move_cnt_q == {MV_W{1'b0}}) && key_any_s && tgt_ok_s) begin
          tcol_d     = tgt_col_s;
          trow_d     = tgt_row_s;
          rom_en_d   = 1'b1;
          rom_addr_d = {tgt_col_s, 5'b00000} + {5'b00000, tgt_row_s};
          state_d    = READ;
        end else begin
          state_d    = WAIT;
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        pcol_d = new_col_s;
        prow_d = new_row_s;
        if (accept_s) begin
          move_cnt_d = MOVE_LOAD_C;
`ifdef MAZE_CTRL_MOVE_CNT_EN
          if (moves_q != 10'd1023) begin
            moves_d = moves_q + 10'd1;
          end else begin
            moves_d = moves_q;
          end
`endif
        end else begin
          move_cnt_d = move_cnt_d;
        end
        if ((new_col_s == EXIT_COL_C) && (new_row_s == EXIT_ROW_C)) begin
          state_d = WIN;
          win_d   = 1'b1;
          bar_d   = 1'b0;
          bar_cnt_d = {BAR_W{1'b0}};
        end else begin
          state_d = WAIT;
        end
      end
      WIN: begin
        bar_cnt_d  = {BAR_W{1'b0}};
        bar_d      = 1'b0;
        move_cnt_d = {MV_W{1'b0}};
        if (start_rise_s) begin
          state_d = IDLE;
          pcol_d  = START_COL_C;
          prow_d  = START_ROW_C;
          win_d   = 1'b0;
        end else begin
          state_d = WIN;
          win_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pcol_d  = START_COL_C;
        prow_d  = START_ROW_C;
        win_d   = 1'b0;
        bar_d   = 1'b0;
      end
    endcase

    // Releasing every key re-arms the repeat timer so a fresh press moves at once.
    if (!key_any_s) begin
      move_cnt_d = {MV_W{1'b0}};
    end else begin
      move_cnt_d = move_cnt_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pcol_q     <= START_COL_C;
      prow_q     <= START_ROW_C;
      tcol_q     <= 6'd0;
      trow_q     <= 6'd0;
      move_cnt_q <= {MV_W{1'b0}};
      bar_cnt_q  <= {BAR_W{1'b0}};
      bar_q      <= 1'b0;
      win_q      <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= 11'd0;
      start_q    <= 1'b0;
`ifdef MAZE_CTRL_MOVE_CNT_EN
      moves_q    <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      pcol_q     <= pcol_d;
      prow_q     <= prow_d;
      tcol_q     <= tcol_d;
      trow_q     <= trow_d;
      move_cnt_q <= move_cnt_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_q      <= bar_d;
      win_q      <= win_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      start_q    <= i_start;
`ifdef MAZE_CTRL_MOVE_CNT_EN
      moves_q    <= moves_d;
`endif
    end
  end

  assign o_rom_en      = rom_en_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_player_bcol = pcol_q;
  assign o_player_brow = prow_q;
  assign o_exit_bcol   = EXIT_COL_C;
  assign o_exit_brow   = EXIT_ROW_C;
  assign o_update_bar  = bar_q;
  assign o_win         = win_q;
`ifdef MAZE_CTRL_MOVE_CNT_EN
  assign o_moves       = moves_q;
`endif

endmodule

// File: tb/tb_maze_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_game_ctrl
//
// Directed self-checking bench for maze_game_ctrl. A small ROM model returns
// the word held in rom_word one cycle after o_rom_en. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_maze_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_frame_tick;
  logic        i_start;
  logic        i_up, i_down, i_left, i_right;
  logic        o_rom_en;
  logic [10:0] o_rom_addr;
  logic [15:0] i_rom_data;
  logic [5:0]  o_player_bcol, o_player_brow;
  logic [5:0]  o_exit_bcol, o_exit_brow;
  logic        o_update_bar;
  logic        o_win;
`ifdef MAZE_CTRL_MOVE_CNT_EN
  logic [9:0]  o_moves;
`endif

  logic [15:0] rom_word;
  int          n_checks = 0;
  int          n_errors = 0;

  maze_game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_tick  (i_frame_tick),
    .i_start       (i_start),
    .i_up          (i_up),
    .i_down        (i_down),
    .i_left        (i_left),
    .i_right       (i_right),
    .o_rom_en      (o_rom_en),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (i_rom_data),
    .o_player_bcol (o_player_bcol),
    .o_player_brow (o_player_brow),
    .o_exit_bcol   (o_exit_bcol),
    .o_exit_brow   (o_exit_brow),
    .o_update_bar  (o_update_bar),
    .o_win         (o_win)
`ifdef MAZE_CTRL_MOVE_CNT_EN
    ,
    .o_moves       (o_moves)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: one-cycle read latency.
  always @(posedge clk) begin
    if (o_rom_en) i_rom_data <= rom_word;
  end

  task automatic pulse_tick();
    @(negedge clk) i_frame_tick = 1'b1;
    @(negedge clk) i_frame_tick = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right
  task automatic do_move(input int dir, input logic [15:0] word);
    rom_word = word;
    i_up = (dir == 0); i_down = (dir == 1); i_left = (dir == 2); i_right = (dir == 3);
    pulse_tick();
    @(negedge clk);
    @(negedge clk);
    i_up = 1'b0; i_down = 1'b0; i_left = 1'b0; i_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; i_frame_tick = 1'b0; i_start = 1'b0;
    i_up = 1'b0; i_down = 1'b0; i_left = 1'b0; i_right = 1'b0;
    rom_word = 16'h0000; i_rom_data = 16'h0000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_player_bcol !== 6'd1 || o_player_brow !== 6'd1) begin
      n_errors++; $display("FAIL reset_player: got (%0d,%0d) expected (1,1)", o_player_bcol, o_player_brow);
    end
    n_checks++;
    if (o_rom_en !== 1'b0 || o_rom_addr !== 11'd0 || o_update_bar !== 1'b0 || o_win !== 1'b0) begin
      n_errors++; $display("FAIL reset_outputs: got en=%0b addr=%0d bar=%0b win=%0b expected 0,0,0,0",
                           o_rom_en, o_rom_addr, o_update_bar, o_win);
    end
    n_checks++;
    if (o_exit_bcol !== 6'd38 || o_exit_brow !== 6'd28) begin
      n_errors++; $display("FAIL exit_pos: got (%0d,%0d) expected (38,28)", o_exit_bcol, o_exit_brow);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_move();
    start_pulse();
    rom_word = 16'h0000;
    i_right = 1'b1;
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b1 || o_rom_addr !== 11'd65) begin
      n_errors++; $display("FAIL read_right: got en=%0b addr=%0d expected en=1 addr=65", o_rom_en, o_rom_addr);
    end
    @(negedge clk);
    n_checks++;
    if (o_rom_en !== 1'b0 || o_player_bcol !== 6'd1) begin
      n_errors++; $display("FAIL check_cycle: got en=%0b col=%0d expected en=0 col=1", o_rom_en, o_player_bcol);
    end
    @(negedge clk);
    n_checks++;
    if (o_player_bcol !== 6'd2 || o_player_brow !== 6'd1) begin
      n_errors++; $display("FAIL move_right: got (%0d,%0d) expected (2,1)", o_player_bcol, o_player_brow);
    end
  endtask

  task automatic test_repeat_delay();
    int en_seen = 0;
    for (int k = 0; k < 8; k++) begin
      pulse_tick();
      if (o_rom_en) en_seen++;
    end
    n_checks++;
    if (en_seen != 0) begin
      n_errors++; $display("FAIL repeat_hold: got %0d reads in 8 ticks expected 0", en_seen);
    end
    rom_word = 16'hF000;
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b1 || o_rom_addr !== 11'd97) begin
      n_errors++; $display("FAIL repeat_read: got en=%0b addr=%0d expected en=1 addr=97", o_rom_en, o_rom_addr);
    end
    @(negedge clk); @(negedge clk);
    i_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wall();
    rom_word = 16'hF000;
    i_down = 1'b1;
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b1 || o_rom_addr !== 11'd66) begin
      n_errors++; $display("FAIL read_down: got en=%0b addr=%0d expected en=1 addr=66", o_rom_en, o_rom_addr);
    end
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (o_player_bcol !== 6'd2 || o_player_brow !== 6'd1) begin
      n_errors++; $display("FAIL wall_block: got (%0d,%0d) expected (2,1)", o_player_bcol, o_player_brow);
    end
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b1) begin
      n_errors++; $display("FAIL wall_retry: got en=%0b expected 1", o_rom_en);
    end
    @(negedge clk); @(negedge clk);
    i_down = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_edge();
    int en_seen = 0;
    do_move(2, 16'h0000);
    do_move(2, 16'h0000);
    do_move(0, 16'h0000);
    n_checks++;
    if (o_player_bcol !== 6'd0 || o_player_brow !== 6'd0) begin
      n_errors++; $display("FAIL reach_origin: got (%0d,%0d) expected (0,0)", o_player_bcol, o_player_brow);
    end
    i_up = 1'b1; i_left = 1'b1;
    repeat (5) begin
      pulse_tick();
      if (o_rom_en) en_seen++;
      @(negedge clk);
      if (o_rom_en) en_seen++;
    end
    n_checks++;
    if (en_seen != 0 || o_player_bcol !== 6'd0 || o_player_brow !== 6'd0) begin
      n_errors++; $display("FAIL edge_reject: got reads=%0d pos=(%0d,%0d) expected reads=0 pos=(0,0)",
                           en_seen, o_player_bcol, o_player_brow);
    end
    i_up = 1'b0; i_left = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_win();
    int en_seen = 0;
    repeat (37) do_move(3, 16'h0000);
    repeat (28) do_move(1, 16'h0000);
    n_checks++;
    if (o_player_bcol !== 6'd37 || o_player_brow !== 6'd28 || o_win !== 1'b0) begin
      n_errors++; $display("FAIL pre_exit: got (%0d,%0d) win=%0b expected (37,28) win=0",
                           o_player_bcol, o_player_brow, o_win);
    end
    do_move(3, 16'h1234);
    n_checks++;
    if (o_player_bcol !== 6'd38 || o_player_brow !== 6'd28 || o_win !== 1'b1) begin
      n_errors++; $display("FAIL win_move: got (%0d,%0d) win=%0b expected (38,28) win=1",
                           o_player_bcol, o_player_brow, o_win);
    end
    i_left = 1'b1;
    repeat (3) begin
      pulse_tick();
      if (o_rom_en) en_seen++;
    end
    n_checks++;
    if (en_seen != 0 || o_player_bcol !== 6'd38 || o_win !== 1'b1) begin
      n_errors++; $display("FAIL win_frozen: got reads=%0d col=%0d win=%0b expected 0,38,1",
                           en_seen, o_player_bcol, o_win);
    end
    i_left = 1'b0;
    start_pulse();
    n_checks++;
    if (o_player_bcol !== 6'd1 || o_player_brow !== 6'd1 || o_win !== 1'b0) begin
      n_errors++; $display("FAIL restart: got (%0d,%0d) win=%0b expected (1,1) win=0",
                           o_player_bcol, o_player_brow, o_win);
    end
  endtask

  task automatic test_bar();
    int hi_cnt = 0;
    int hi_first = 0;
    int hi_second = 0;
    start_pulse();
    for (int k = 1; k <= 130; k++) begin
      pulse_tick();
      if (o_update_bar) begin
        hi_cnt++;
        if (hi_cnt == 1) hi_first = k;
        if (hi_cnt == 2) hi_second = k;
      end
    end
    n_checks++;
    if (hi_cnt != 2 || hi_first != 60 || hi_second != 120) begin
      n_errors++; $display("FAIL update_bar: got count=%0d at %0d,%0d expected count=2 at 60,120",
                           hi_cnt, hi_first, hi_second);
    end
  endtask

  task automatic test_reset_mid_read();
    do_move(3, 16'h0000);
    i_right = 1'b1;
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b1 || o_player_bcol !== 6'd2) begin
      n_errors++; $display("FAIL pre_reset_read: got en=%0b col=%0d expected en=1 col=2", o_rom_en, o_player_bcol);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_rom_en !== 1'b0 || o_player_bcol !== 6'd1 || o_player_brow !== 6'd1 || o_rom_addr !== 11'd0) begin
      n_errors++; $display("FAIL reset_in_read: got en=%0b pos=(%0d,%0d) addr=%0d expected en=0 pos=(1,1) addr=0",
                           o_rom_en, o_player_bcol, o_player_brow, o_rom_addr);
    end
    rst = 1'b1;
    pulse_tick();
    n_checks++;
    if (o_rom_en !== 1'b0 || o_player_bcol !== 6'd1) begin
      n_errors++; $display("FAIL idle_after_reset: got en=%0b col=%0d expected en=0 col=1", o_rom_en, o_player_bcol);
    end
    i_right = 1'b0;
    @(negedge clk);
  endtask

`ifdef MAZE_CTRL_MOVE_CNT_EN
  task automatic test_move_count();
    start_pulse();
    do_move(3, 16'h0000);
    do_move(3, 16'h0000);
    do_move(1, 16'hF000);
    do_move(1, 16'h0000);
    n_checks++;
    if (o_moves !== 10'd3 || o_player_bcol !== 6'd3 || o_player_brow !== 6'd2) begin
      n_errors++; $display("FAIL move_count: got moves=%0d pos=(%0d,%0d) expected moves=3 pos=(3,2)",
                           o_moves, o_player_bcol, o_player_brow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_move();
    test_repeat_delay();
    test_wall();
    test_edge();
    test_win();
    test_bar();
    test_reset_mid_read();
`ifdef MAZE_CTRL_MOVE_CNT_EN
    test_move_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Game controller that sequences the maze video datapath.
- Holds the player and exit block coordinates that drive the frame renderer.
- Validates each requested move by reading the maze ROM through its second read port (address = row + col*32, 1-cycle read latency).
- Drives the progress-bar update strobe and detects the win condition. Sits between the button inputs and the frame renderer.

Parameters:
- START_COL, 1, player block column after reset/restart
- START_ROW, 1, player block row after reset/restart
- EXIT_COL, 38, exit block column
- EXIT_ROW, 28, exit block row
- MAX_COL, 39, last legal block column (40 columns)
- MAX_ROW, 29, last legal block row (30 rows)
- FLOOR_VAL, 16'h0000, ROM word meaning "walkable"; any other value is a wall
- MOVE_FRAMES, 8, frames between auto-repeated moves while a key is held
- BAR_FRAMES, 60, frames between progress-bar update strobes

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- i_frame_tick  input  1  one-cycle pulse per video frame
- i_start  input  1  start/restart request (rising edge used)
- i_up, i_down, i_left, i_right  input  1 each  direction keys, level, already debounced
- o_rom_en  output  1  maze ROM port-B read enable
- o_rom_addr  output  11  maze ROM port-B address
- i_rom_data  input  16  maze ROM port-B data, valid 1 cycle after o_rom_en
- o_player_bcol  output  6  player block column
- o_player_brow  output  6  player block row
- o_exit_bcol  output  6  exit block column (constant EXIT_COL)
- o_exit_brow  output  6  exit block row (constant EXIT_ROW)
- o_update_bar  output  1  progress-bar update level, held for one frame
- o_win  output  1  player reached exit

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; player=(START_COL,START_ROW); o_rom_en=0, o_rom_addr=0, o_update_bar=0, o_win=0.
  - All counters are 0; the start edge-detect register is 0.
  - Reset wins over every other event, including mid-READ/CHECK; the pending move is discarded.
- All outputs are registered.
- IDLE:
  - Player is held at start, timers are cleared, keys are ignored.
  - A rising edge of i_start moves the state to WAIT.
- WAIT:
  - On i_frame_tick with move_cnt==0 and at least one key held, latch the target. Priority is up > down > left > right.
  - up = row-1, down = row+1, left = col-1, right = col+1.
  - A target outside 0..MAX_COL / 0..MAX_ROW (no wrap-around) is rejected: no ROM access, stay in WAIT.
  - A legal target goes to READ.
- READ (exactly 1 cycle):
  - o_rom_en=1, o_rom_addr = trow + tcol*32 (11-bit, truncated).
  - The ROM is read in the cycle after the accepting tick. o_rom_en is 0 in every other state.
- CHECK (1 cycle):
  - If i_rom_data==FLOOR_VAL, or the target equals the exit, the player takes the target and move_cnt=MOVE_FRAMES.
  - Otherwise the position is unchanged and move_cnt is not loaded.
  - Next state is WIN if the new position equals the exit, else WAIT.
  - Latency: new position is visible on the outputs 3 cycles after the accepting tick.
- WIN:
  - o_win=1, position frozen, o_update_bar=0, keys ignored.
  - A rising edge of i_start returns to IDLE (player back to start, o_win=0).
- move_cnt:
  - Decrements on each i_frame_tick when nonzero, in WAIT/READ/CHECK.
  - Forced to 0 in any cycle where no key is held, so a fresh press moves on the next tick.
- bar_cnt:
  - Increments on each i_frame_tick in WAIT/READ/CHECK.
  - On a tick with bar_cnt==BAR_FRAMES-1: bar_cnt=0 and o_update_bar=1.
  - o_update_bar clears on the next i_frame_tick.
  - Cleared in IDLE/WIN.
- Simultaneous events:
  - A tick arriving during READ/CHECK updates the counters but cannot start a new move.
  - An i_start edge outside IDLE/WIN is ignored.

Optional Feature:
- Macro MAZE_CTRL_MOVE_CNT_EN.
- When defined:
  - Adds output o_moves (10 bits).
  - Cleared at reset and in IDLE.
  - +1 on each accepted move in CHECK, saturating at 1023.
  - Frozen in WIN.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then i_start pulse, hold i_right, ROM returns 16'h0000 → one o_rom_en pulse with addr=1+2*32=65; player=(2,1) 3 cycles after the tick; next move no earlier than 8 ticks later.
- Player at (2,1), hold i_down, ROM returns 16'hF000 → o_rom_addr=2+2*32=66; player stays (2,1); move_cnt not loaded, so a retry occurs on the next tick.
- Player at (0,0), hold i_up and i_left together → no o_rom_en pulse, player stays (0,0) across 5 ticks.
- Player at (37,28), hold i_right, ROM returns 16'h1234 → player=(38,28), o_win=1; further keys ignored; i_start edge → IDLE, player=(1,1), o_win=0.
- 130 ticks in WAIT with no keys → o_update_bar high exactly twice, each for one frame (ticks 60 and 120); assert rst low during READ → next cycle o_rom_en=0, state IDLE, player=(1,1).
- With MAZE_CTRL_MOVE_CNT_EN defined: 3 accepted moves plus 1 wall-blocked move → o_moves=3.
